spi_target: RTL

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronizes the master's SCLK/SSn/MOSI into HCLK,
// shifts bytes in/out MSB first, buffers received bytes in a small FIFO and
// returns bytes from a single TX holding register.
module spi_target #(
   parameter int SYNC_STAGES = 2,
   parameter int RX_DEPTH    = 4
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       SCLK,
   input  logic       SSn,
   input  logic       MOSI,
   output logic       MISO,
   output logic       MISO_OE,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       tx_underrun,
   output logic       busy
);

   localparam int AW = $clog2(RX_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ssn_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   ssn_d;
   logic [1:0]             flush_cnt;
   logic                   armed;
   logic [2:0]             bit_cnt;
   logic                   byte_done;
   logic                   underrun_pending;
   logic [7:0]             rx_shift;
   logic [7:0]             tx_shift;
   logic [7:0]             hold_data;
   logic                   hold_full;
   logic [7:0]             rx_mem [RX_DEPTH];
   logic [AW:0]            wr_ptr;
   logic [AW:0]            rd_ptr;

   logic sclk_s, ssn_s, mosi_s;
   logic sclk_rise, sclk_fall, ssn_rise, ssn_fall;
   logic rx_empty, rx_full, pop, push_req, push_ok, accept_tx;
   logic [7:0] rx_next_byte;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ssn_s     = ssn_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ssn_rise  = ssn_s & ~ssn_d;
   assign ssn_fall  = ~ssn_s & ssn_d;

   assign rx_empty     = (wr_ptr == rd_ptr);
   assign rx_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop          = !rx_empty && rx_ready;
   assign rx_next_byte = {rx_shift[6:0], mosi_s};
   assign push_req     = (state == ACTIVE) && !ssn_rise && sclk_rise && (bit_cnt == 3'd7);
   assign push_ok      = push_req && (!rx_full || pop);
   assign accept_tx    = tx_valid && !hold_full;

   assign MISO     = (state == ACTIVE) && tx_shift[7];
   assign MISO_OE  = (state == ACTIVE);
   assign busy     = (state == ACTIVE);
   assign tx_ready = !hold_full;
   assign rx_valid = !rx_empty;
   assign rx_data  = rx_empty ? 8'h00 : rx_mem[rd_ptr[AW-1:0]];

   // Synchronizers, edge detectors, shift engine, holding register and FIFO pointers.
   // The reload at the trailing SCLK fall of a byte must happen before the master's
   // next rise, but a master that simply ends the transfer never uses that byte, so an
   // empty holding register there only raises tx_underrun once the next byte really
   // starts clocking. After reset the select line is only trusted once the synchronizer
   // has flushed and SSn has been seen high, so a transfer cut by reset is not resumed.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state            <= IDLE;
         sclk_sync        <= '0;
         ssn_sync         <= '1;
         mosi_sync        <= '0;
         sclk_d           <= 1'b0;
         ssn_d            <= 1'b1;
         flush_cnt        <= 2'(SYNC_STAGES);
         armed            <= 1'b0;
         bit_cnt          <= 3'd0;
         byte_done        <= 1'b0;
         underrun_pending <= 1'b0;
         rx_shift         <= 8'h00;
         tx_shift         <= 8'h00;
         hold_data        <= 8'h00;
         hold_full        <= 1'b0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         rx_overrun       <= 1'b0;
         tx_underrun      <= 1'b0;
      end else begin
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         ssn_sync    <= {ssn_sync[SYNC_STAGES-2:0], SSn};
         mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_d      <= sclk_s;
         ssn_d       <= ssn_s;
         tx_underrun <= 1'b0;
         rx_overrun  <= push_req && !push_ok;

         if (flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
         end else if (ssn_s) begin
            armed <= 1'b1;
         end

         if (accept_tx) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         case (state)
            IDLE: begin
               if (armed && ssn_fall) begin
                  state            <= ACTIVE;
                  bit_cnt          <= 3'd0;
                  byte_done        <= 1'b0;
                  underrun_pending <= 1'b0;
                  rx_shift         <= 8'h00;
                  if (hold_full) begin
                     tx_shift  <= hold_data;
                     hold_full <= 1'b0;
                  end else begin
                     tx_shift    <= 8'h00;
                     tx_underrun <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (ssn_rise) begin
                  state            <= IDLE;
                  bit_cnt          <= 3'd0;
                  byte_done        <= 1'b0;
                  underrun_pending <= 1'b0;
                  rx_shift         <= 8'h00;
               end else if (sclk_rise) begin
                  rx_shift  <= rx_next_byte;
                  bit_cnt   <= bit_cnt + 3'd1;
                  byte_done <= (bit_cnt == 3'd7);
                  if (underrun_pending) begin
                     tx_underrun      <= 1'b1;
                     underrun_pending <= 1'b0;
                  end
               end else if (sclk_fall) begin
                  if (byte_done) begin
                     byte_done <= 1'b0;
                     if (hold_full) begin
                        tx_shift  <= hold_data;
                        hold_full <= 1'b0;
                     end else begin
                        tx_shift         <= 8'h00;
                        underrun_pending <= 1'b1;
                     end
                  end else begin
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while empty since rx_data is gated.
   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         rx_mem[wr_ptr[AW-1:0]] <= rx_next_byte;
      end
   end

endmodule
